// File: rtl/borrow_serial_sub.sv
// borrow_serial_sub: multi-cycle subtractor d = a - b - bin.
// One 4-bit borrow-lookahead slice is processed per clock, LSB slice first.
// A registered borrow links consecutive slices, so the combinational depth
// is a single 4-bit lookahead cell regardless of WIDTH.
// WIDTH must be a multiple of 4 in the range 4..64.
module borrow_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int SLICES = WIDTH / 4;
    // The counter is kept at least one bit wide so WIDTH=4 still elaborates.
    localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int SHW    = KW + 2;

    localparam logic [KW-1:0]    K_LAST     = KW'(SLICES - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'(4'hF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Captured operands, inter-slice borrow and slice counter.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             borrow;
    logic [KW-1:0]    k;

    // Difference bits of completed slices; only copied to d at completion.
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_next;

    // Registered results.
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ovf_q;

    // Slice datapath.
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] a_shifted;
    logic [WIDTH-1:0] b_shifted;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       gen;
    logic [3:0]       prop;
    logic [4:0]       brw;
    logic [3:0]       slice_d;
    logic             last_slice;
    logic             accept;
    logic             ovf_next;

    assign last_slice = (k == K_LAST);
    // A request is taken whenever no operation is running; DONE counts as
    // free so a start coinciding with done chains the next operation.
    assign accept     = start && (state != RUN);

    // Select the active slice of both operands.
    assign shamt     = {k, 2'b00};
    assign a_shifted = op_a >> shamt;
    assign b_shifted = op_b >> shamt;
    assign slice_a   = a_shifted[3:0];
    assign slice_b   = b_shifted[3:0];

    // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
    assign gen  = ~slice_a & slice_b;
    assign prop = ~(slice_a ^ slice_b);

    // Full lookahead: every slice borrow is a flat sum of products of the
    // slice-in borrow, with no ripple between bit positions.
    assign brw[0] = borrow;
    assign brw[1] = gen[0]
                  | (prop[0] & borrow);
    assign brw[2] = gen[1]
                  | (prop[1] & gen[0])
                  | (prop[1] & prop[0] & borrow);
    assign brw[3] = gen[2]
                  | (prop[2] & gen[1])
                  | (prop[2] & prop[1] & gen[0])
                  | (prop[2] & prop[1] & prop[0] & borrow);
    assign brw[4] = gen[3]
                  | (prop[3] & gen[2])
                  | (prop[3] & prop[2] & gen[1])
                  | (prop[3] & prop[2] & prop[1] & gen[0])
                  | (prop[3] & prop[2] & prop[1] & prop[0] & borrow);

    assign slice_d = slice_a ^ slice_b ^ brw[3:0];

    // Shadow with the current slice merged in; on the final slice this is
    // the complete difference, which feeds d and the overflow test directly.
    assign shadow_next = (shadow & ~(SLICE_MASK << shamt))
                       | (WIDTH'(slice_d) << shamt);

    // Overflow: operand signs differ and the result sign differs from a.
    assign ovf_next = (op_a[WIDTH-1] ^ op_b[WIDTH-1])
                    & (shadow_next[WIDTH-1] ^ op_a[WIDTH-1]);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer.
    // NOTE: state_next is assigned a default before the case so that every
    // path drives it and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-slice update and result load.
    // NOTE: operand, shadow and result registers are all cleared on reset so
    // that a reset, including one mid-operation, leaves a known zero state.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            borrow <= 1'b0;
            k      <= '0;
            shadow <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            op_a   <= a;
            op_b   <= b;
            borrow <= bin;
            k      <= '0;
        end else if (state == RUN) begin
            shadow <= shadow_next;
            borrow <= brw[4];
            if (last_slice) begin
                d_q    <= shadow_next;
                bout_q <= brw[4];
                ovf_q  <= ovf_next;
            end else begin
                k <= k + KW'(1);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_borrow_serial_sub.sv
// Self-checking bench for borrow_serial_sub at WIDTH=16.
// Expected results come from an integer reference model and are queued when
// an operation is launched, then popped when done is observed.
module tb_borrow_serial_sub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } res_t;

    res_t sb[$];
    int   total = 0;
    int   bad   = 0;

    borrow_serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: unsigned wide subtraction for d/bout, signed range test for ovf.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
        logic [W:0] full;
        int         sx;
        int         sy;
        int         s;
        res_t       r;
        full   = {1'b0, x} - {1'b0, y} - (W+1)'(c);
        sx     = int'($signed(x));
        sy     = int'($signed(y));
        s      = sx - sy - int'(c);
        r.d    = full[W-1:0];
        r.bout = full[W];
        r.ovf  = (s > 32767) || (s < -32768);
        return r;
    endfunction

    // Drive a request at a negedge and queue its expected result.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a     = x;
        b     = y;
        bin   = c;
        start = 1'b1;
        sb.push_back(model(x, y, c));
    endtask

    // Wait for done (bounded); cycles=-1 on timeout. Drops start each cycle.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0001;
        bin   = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, d, bout, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b d=%h bout=%b ovf=%b, want all 0",
                     busy, done, d, bout, ovf);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int   cyc;
        int   bc;
        res_t exp;
        launch(16'h1234, 16'h0034, 1'b0);   // d=1200 bout=0 ovf=0
        wait_done(cyc, bc);
        total++;
        if (cyc !== 5) begin
            bad++;
            $display("FAIL basic_latency: done after %0d cycles, want 5 (-1 = timeout)", cyc);
        end
        total++;
        if (bc !== 4) begin
            bad++;
            $display("FAIL basic_busy: busy for %0d cycles, want 4", bc);
        end
        exp = sb.pop_front();
        total++;
        if ({d, bout, ovf} !== exp) begin
            bad++;
            $display("FAIL basic_result: d=%h bout=%b ovf=%b, want d=%h bout=%b ovf=%b",
                     d, bout, ovf, exp.d, exp.bout, exp.ovf);
        end
    endtask

    task automatic test_underflow;
        int   cyc;
        int   bc;
        res_t exp;
        launch(16'h0000, 16'h0001, 1'b0);   // d=FFFF bout=1 ovf=0
        wait_done(cyc, bc);
        exp = sb.pop_front();
        total++;
        if (cyc !== 5 || {d, bout, ovf} !== exp) begin
            bad++;
            $display("FAIL underflow: cyc=%0d d=%h bout=%b ovf=%b, want cyc=5 d=%h bout=%b ovf=%b",
                     cyc, d, bout, ovf, exp.d, exp.bout, exp.ovf);
        end
    endtask

    task automatic test_overflow;
        logic [W-1:0] xs[2] = '{16'h8000, 16'h7FFF};
        logic [W-1:0] ys[2] = '{16'h0001, 16'hFFFF};
        int   cyc;
        int   bc;
        res_t exp;
        // 8000-0001 -> 7FFF bout=0 ovf=1 ; 7FFF-FFFF -> 8000 bout=1 ovf=1
        for (int i = 0; i < 2; i++) begin
            launch(xs[i], ys[i], 1'b0);
            wait_done(cyc, bc);
            exp = sb.pop_front();
            total++;
            if (cyc !== 5 || {d, bout, ovf} !== exp) begin
                bad++;
                $display("FAIL overflow_%0d: cyc=%0d d=%h bout=%b ovf=%b, want cyc=5 d=%h bout=%b ovf=%b",
                         i, cyc, d, bout, ovf, exp.d, exp.bout, exp.ovf);
            end
        end
    endtask

    task automatic test_borrow_chain;
        logic [W-1:0] xs[2] = '{16'h0005, 16'h1000};
        logic [W-1:0] ys[2] = '{16'h0005, 16'h0001};
        logic         cs[2] = '{1'b1, 1'b0};
        int   cyc;
        int   bc;
        res_t exp;
        // 0005-0005-1 -> FFFF bout=1 ; 1000-0001 -> 0FFF bout=0
        for (int i = 0; i < 2; i++) begin
            launch(xs[i], ys[i], cs[i]);
            wait_done(cyc, bc);
            exp = sb.pop_front();
            total++;
            if (cyc !== 5 || {d, bout, ovf} !== exp) begin
                bad++;
                $display("FAIL chain_%0d: cyc=%0d d=%h bout=%b ovf=%b, want cyc=5 d=%h bout=%b ovf=%b",
                         i, cyc, d, bout, ovf, exp.d, exp.bout, exp.ovf);
            end
        end
    endtask

    task automatic test_ignore_start;
        int   cyc;
        int   bc;
        int   extra;
        res_t exp;
        launch(16'h0F0F, 16'h00F1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);                     // RUN: change inputs, pulse start
        a     = 16'hFFFF;
        b     = 16'h1111;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        total++;
        if (cyc !== 2) begin
            bad++;
            $display("FAIL ignore_latency: done after %0d more cycles, want 2", cyc);
        end
        exp = sb.pop_front();
        total++;
        if ({d, bout, ovf} !== exp) begin
            bad++;
            $display("FAIL ignore_result: d=%h bout=%b ovf=%b, want d=%h bout=%b ovf=%b",
                     d, bout, ovf, exp.d, exp.bout, exp.ovf);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL ignore_no_relaunch: %0d busy/done cycles seen, want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int   cyc;
        int   bc;
        int   held_bad;
        res_t exp;
        res_t old;
        launch(16'hABCD, 16'h1234, 1'b0);
        wait_done(cyc, bc);
        exp = sb.pop_front();
        total++;
        if (cyc !== 5 || {d, bout, ovf} !== exp) begin
            bad++;
            $display("FAIL b2b_first: cyc=%0d d=%h bout=%b ovf=%b, want cyc=5 d=%h bout=%b ovf=%b",
                     cyc, d, bout, ovf, exp.d, exp.bout, exp.ovf);
        end
        for (int n = 0; n < 3; n++) begin
            old = {d, bout, ovf};
            launch(W'($urandom), W'($urandom), 1'($urandom_range(1)));  // during done
            cyc      = -1;
            held_bad = 0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (done) begin
                    cyc = i;
                    break;
                end
                if ({d, bout, ovf} !== old) held_bad++;
            end
            total++;
            if (cyc !== 5 || held_bad !== 0) begin
                bad++;
                $display("FAIL b2b_timing_%0d: cyc=%0d held_bad=%0d, want cyc=5 held_bad=0",
                         n, cyc, held_bad);
            end
            exp = sb.pop_front();
            total++;
            if ({d, bout, ovf} !== exp) begin
                bad++;
                $display("FAIL b2b_result_%0d: d=%h bout=%b ovf=%b, want d=%h bout=%b ovf=%b",
                         n, d, bout, ovf, exp.d, exp.bout, exp.ovf);
            end
        end
    endtask

    task automatic test_mid_reset;
        int   cyc;
        int   bc;
        int   spurious;
        res_t exp;
        launch(16'h4321, 16'h1234, 1'b0);
        @(negedge clk);                     // RUN cycle 1
        start = 1'b0;
        @(negedge clk);                     // RUN cycle 2
        @(negedge clk);                     // RUN cycle 3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, d, bout, ovf} !== '0) begin
            bad++;
            $display("FAIL midreset_clear: busy=%b done=%b d=%h bout=%b ovf=%b, want all 0",
                     busy, done, d, bout, ovf);
        end
        void'(sb.pop_front());              // aborted operation produces nothing
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++;
            $display("FAIL midreset_no_done: %0d busy/done cycles, want 0", spurious);
        end
        launch(16'h0100, 16'h0201, 1'b1);
        wait_done(cyc, bc);
        exp = sb.pop_front();
        total++;
        if (cyc !== 5 || {d, bout, ovf} !== exp) begin
            bad++;
            $display("FAIL midreset_after: cyc=%0d d=%h bout=%b ovf=%b, want cyc=5 d=%h bout=%b ovf=%b",
                     cyc, d, bout, ovf, exp.d, exp.bout, exp.ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_overflow();
        test_borrow_chain();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/borrow_serial_sub.md
# borrow_serial_sub

Multi-cycle subtractor computing `d = a - b - bin` over a WIDTH-bit operand, one 4-bit borrow-lookahead slice per clock, LSB slice first. A registered borrow links the slices. It pairs with the 4-bit carry-lookahead adder in the Basic arithmetic library. It targets datapaths that trade latency for a small, fixed-depth lookahead cell, and uses a start/busy/done handshake.

## Interface

Parameters:
- `WIDTH`, 16, operand width in bits; must be a multiple of 4 in the range 4..64. `SLICES = WIDTH/4`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `a`  in  WIDTH  minuend; captured on the accepting edge
- `b`  in  WIDTH  subtrahend; captured on the accepting edge
- `bin`  in  1  borrow-in; captured on the accepting edge
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse; results valid from this cycle
- `d`  out  WIDTH  difference, modulo 2^WIDTH
- `bout`  out  1  borrow-out; 1 when unsigned `a < b + bin`
- `ovf`  out  1  two's-complement overflow of the subtraction

## Operation

States:
- IDLE: waiting for a request.
- RUN: processing slices.
- DONE: one-cycle result strobe.

Transitions:
- IDLE + `start` -> RUN. Capture `a`, `b`, `bin` into internal operand and borrow registers, and clear the slice counter `k`.
- RUN: each edge processes slice `k`, covering bits `4k+3..4k`. While `k < SLICES-1`, increment `k`. At `k = SLICES-1` go to DONE.
- DONE -> IDLE, or directly -> RUN if `start`=1 in that cycle (back-to-back accepted).

Slice arithmetic, per bit i of the slice, with bi = incoming slice borrow:
- Generate: `g_i = ~a_i & b_i`.
- Propagate: `p_i = ~(a_i ^ b_i)`.
- Difference: `d_i = a_i ^ b_i ^ bi`.
- Borrows are full lookahead, with no ripple inside the slice: `b1 = g0 | p0&bi`, `b2 = g1 | p1&g0 | p1&p0&bi`, and so on to `b4`.
- `b4` is registered as the borrow into slice `k+1`.
- Slice difference bits are written into an internal shadow register.

Completion:
- On the edge leaving RUN, the outputs are loaded:
  - `d` from the shadow register, including the final slice.
  - `bout` from the final `b4`.
  - `ovf = (a[W-1]^b[W-1]) & (d[W-1]^a[W-1])`, using the captured operands.
- `d`, `bout` and `ovf` hold until the next completion. Intermediate slices never appear on the outputs.

Other rules:
- `start` while `busy`=1 is ignored. Captured operands are unaffected by input changes after acceptance.
- `bin` enters only slice 0.

## Timing

- Reset: state IDLE, `k`=0, and every output is 0 (`busy`, `done`, `d`, `bout`, `ovf`). The internal registers are cleared.
- `rst` in any state, including mid-RUN, aborts the operation. No `done` pulse follows.
- Accepting edge E0. `busy`=1 in the cycles after E0 through E(SLICES-1).
- Edge E(SLICES) loads the results: `done`=1 and `busy`=0 for exactly one cycle.
- Latency is SLICES+1 cycles from start edge to `done`; WIDTH=16 gives 5.
- Maximum throughput is one operation per SLICES+1 cycles, using a `start` that coincides with `done`.
- `start` and `rst` asserted together: reset wins.
- Worst-case combinational path is one 4-bit lookahead cell plus the borrow register, independent of WIDTH.

## Test plan

All scenarios use WIDTH=16.

- **Basic:** `a`=0x1234, `b`=0x0034, `bin`=0 -> `d`=0x1200, `bout`=0, `ovf`=0. `done` 5 cycles after the start edge and `busy` high for 4 cycles.
- **Underflow:** `a`=0x0000, `b`=0x0001, `bin`=0 -> `d`=0xFFFF, `bout`=1, `ovf`=0.
- **Signed overflow:** `a`=0x8000, `b`=0x0001 -> `d`=0x7FFF, `bout`=0, `ovf`=1. Also `a`=0x7FFF, `b`=0xFFFF -> `d`=0x8000, `bout`=1, `ovf`=1.
- **Borrow-in and cross-slice chain:** `a`=0x0005, `b`=0x0005, `bin`=1 -> `d`=0xFFFF, `bout`=1, `ovf`=0. `a`=0x1000, `b`=0x0001 -> `d`=0x0FFF, borrow propagated through slices 0..2.
- **Handshake:**
  - Change `a`/`b` and pulse `start` mid-RUN -> ignored, and the result matches the captured operands.
  - `start` asserted during the `done` cycle -> the new operation completes 5 cycles later, and the old `d` holds until then.
- **Reset:** assert `rst` in the 3rd RUN cycle -> all outputs 0 on the next cycle, no `done`. A subsequent operation is correct.
